// File: rtl/led_frame_buffer_pkg.sv
// Shared constants and types for the double-buffered LED matrix frame store.
package led_pkg;

   localparam int MATRIX_W   = 32;
   localparam int HALF_ROWS  = 16;
   localparam int PIX_W      = 8;
   localparam int RD_ADDR_W  = 11;
   localparam int HALF_DEPTH = MATRIX_W * HALF_ROWS;

   localparam logic [PIX_W-1:0] PIXEL_MASK = 8'h3F;
   localparam logic [8:0]       LAST_ADDR  = 9'd511;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } fb_state_t;

   typedef logic [8:0] half_addr_t;

   function automatic logic [PIX_W-1:0] mask_pixel(input logic [PIX_W-1:0] p);
      return p & PIXEL_MASK;
   endfunction

endpackage

// File: rtl/led_frame_buffer_fb_bank_ram.sv
// One 512x8 half-panel bank: single write port, synchronous read with a resettable output register.
module fb_bank_ram
   import led_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  half_addr_t       i_waddr,
   input  logic [PIX_W-1:0] i_wdata,
   input  half_addr_t       i_raddr,
   output logic [PIX_W-1:0] o_rdata
);

   logic [PIX_W-1:0] r_mem [HALF_DEPTH];
   logic [PIX_W-1:0] r_rdata;

   // Storage array write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read register, cleared so the driver sees black out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata <= {PIX_W{1'b0}};
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered 32x32 frame store: CPU writes and fills land in the back buffer,
// the scan driver reads the front buffer, and swaps only happen on frame_done.
module led_frame_buffer
   import led_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_wr_valid,
   output logic                 o_wr_ready,
   input  logic [4:0]           i_wr_x,
   input  logic [4:0]           i_wr_y,
   input  logic [PIX_W-1:0]     i_wr_pixel,
   input  logic                 i_fill_valid,
   output logic                 o_fill_ready,
   input  logic [PIX_W-1:0]     i_fill_pixel,
   input  logic                 i_swap_req,
   output logic                 o_swap_pending,
   output logic                 o_swap_ack,
   input  logic                 i_frame_done,
   input  logic [RD_ADDR_W-1:0] i_pix_addr0,
   output logic [PIX_W-1:0]     o_pix0,
   input  logic [RD_ADDR_W-1:0] i_pix_addr1,
   output logic [PIX_W-1:0]     o_pix1,
   output logic                 o_busy
);

   fb_state_t                  r_state;
   fb_state_t                  w_state_nxt;
   logic                       r_front_sel;
   logic                       r_rd_sel;
   logic                       r_swap_pending;
   logic                       r_swap_ack;
   half_addr_t                 r_fill_cnt;
   logic [PIX_W-1:0]           r_fill_pix;
   logic                       w_idle;
   logic                       w_fill_accept;
   logic                       w_wr_accept;
   logic                       w_swap_now;
   logic [3:0]                 w_bank_we;
   half_addr_t                 w_waddr;
   logic [PIX_W-1:0]           w_wdata;
   logic [3:0][PIX_W-1:0]      w_rdata;
   logic                       w_unused_addr_hi;

   assign w_idle         = (r_state == IDLE);
   assign o_fill_ready   = w_idle & ~r_swap_pending;
   assign o_wr_ready     = o_fill_ready & ~i_fill_valid;
   assign w_fill_accept  = i_fill_valid & o_fill_ready;
   assign w_wr_accept    = i_wr_valid & o_wr_ready;
   assign w_swap_now     = i_frame_done & r_swap_pending & w_idle;
   assign o_busy         = (r_state == FILL);
   assign o_swap_pending = r_swap_pending;
   assign o_swap_ack     = r_swap_ack;
   assign w_unused_addr_hi = ^{i_pix_addr0[10:9], i_pix_addr1[10:9]};

   // Fill FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Fill FSM next state: one pass over all 512 addresses, then back to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_fill_accept) w_state_nxt = FILL;
            else               w_state_nxt = IDLE;
         end
         FILL: begin
            if (r_fill_cnt == LAST_ADDR) w_state_nxt = IDLE;
            else                         w_state_nxt = FILL;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Swap bookkeeping, fill counter/colour, and the read-side buffer select.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_front_sel    <= 1'b0;
         r_rd_sel       <= 1'b0;
         r_swap_pending <= 1'b0;
         r_swap_ack     <= 1'b0;
         r_fill_cnt     <= 9'd0;
         r_fill_pix     <= {PIX_W{1'b0}};
      end else begin
         r_rd_sel   <= r_front_sel;
         r_swap_ack <= w_swap_now;
         // A swap_req landing on the swap edge is absorbed by that swap.
         if (w_swap_now) begin
            r_front_sel    <= ~r_front_sel;
            r_swap_pending <= 1'b0;
         end else if (i_swap_req) begin
            r_swap_pending <= 1'b1;
         end
         if (r_state == FILL) begin
            r_fill_cnt <= r_fill_cnt + 9'd1;
         end
         if (w_fill_accept) begin
            r_fill_pix <= mask_pixel(i_fill_pixel);
         end
      end
   end

   // Back-buffer write mux; bank index is {buffer, half}.
   always_comb begin
      w_bank_we = 4'b0000;
      w_waddr   = r_fill_cnt;
      w_wdata   = r_fill_pix;
      if (r_state == FILL) begin
         w_bank_we[{~r_front_sel, 1'b0}] = 1'b1;
         w_bank_we[{~r_front_sel, 1'b1}] = 1'b1;
      end else if (w_wr_accept) begin
         w_bank_we[{~r_front_sel, i_wr_y[4]}] = 1'b1;
         w_waddr = {i_wr_y[3:0], i_wr_x};
         w_wdata = mask_pixel(i_wr_pixel);
      end else begin
         w_bank_we = 4'b0000;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_bank
      fb_bank_ram u_ram (
         .clk     (clk),
         .rst     (rst),
         .i_we    (w_bank_we[g]),
         .i_waddr (w_waddr),
         .i_wdata (w_wdata),
         .i_raddr ((g % 2 == 1) ? i_pix_addr1[8:0] : i_pix_addr0[8:0]),
         .o_rdata (w_rdata[g])
      );
   end

   // r_rd_sel holds the front select seen at the read edge, so a swap-cycle read returns old-front data.
   assign o_pix0 = r_rd_sel ? w_rdata[2] : w_rdata[0];
   assign o_pix1 = r_rd_sel ? w_rdata[3] : w_rdata[1];

endmodule
